// File: rtl/clp_pkg.sv
// -----------------------------------------------------------------------------
// clp_pkg
// Shared definitions for the CLP instruction dispatcher:
//   - INST_WIDTH : width of one layer instruction word
//   - OP_HALT    : CLP type code that terminates a program
//   - state_t    : dispatcher FSM state encoding (3 bits)
//   - field offsets of the layer instruction word
//   - inst_type(): extracts the CLP type field from an instruction word
// -----------------------------------------------------------------------------
package clp_pkg;

    localparam int INST_WIDTH = 100;

    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction field offsets (msb/lsb)
    localparam int F_TYPE_MSB      = 3;
    localparam int F_TYPE_LSB      = 0;
    localparam int F_FEAT_ADDR_MSB = 84;
    localparam int F_FEAT_ADDR_LSB = 70;
    localparam int F_AMOUNT_MSB    = 69;
    localparam int F_AMOUNT_LSB    = 60;
    localparam int F_WADDR_MSB     = 59;
    localparam int F_WADDR_LSB     = 50;
    localparam int F_WAMOUNT_MSB   = 49;
    localparam int F_WAMOUNT_LSB   = 40;
    localparam int F_SCALER_MSB    = 39;
    localparam int F_SCALER_LSB    = 30;
    localparam int F_OUT_ADDR_MSB  = 29;
    localparam int F_OUT_ADDR_LSB  = 20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_LATCH   = 3'd3,
        ST_ISSUE   = 3'd4,
        ST_ACK     = 3'd5,
        ST_RUN     = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    function automatic logic [3:0] inst_type(input logic [INST_WIDTH-1:0] w_inst);
        return w_inst[F_TYPE_MSB:F_TYPE_LSB];
    endfunction

endpackage

// File: rtl/clp_inst_dispatch.sv
// -----------------------------------------------------------------------------
// clp_inst_dispatch
// Upstream sequencer for CLP_ctr. Fetches layer instructions from instruction
// RAM starting at prog_base, presents each one on clp_instruction, pulses
// clp_enable for one cycle, waits for the CLP_ctr busy period (clp_state high
// then low) and moves on. A program ends on a HALT opcode (not issued, not
// counted), after MAX_INST issued instructions, or on a fault.
//
// Optional feature (compile-time macro DISPATCH_TIMEOUT_EN):
//   defined     : a 16-bit watchdog counts RUN cycles; reaching TIMEOUT_CYC
//                 sets error and abandons the program.
//   not defined : RUN waits indefinitely; error comes only from ACK timeout.
//
// Ports:
//   clk             in  clock, rising edge
//   rst             in  asynchronous reset, active-high
//   start           in  1-cycle start pulse, ignored while busy
//   prog_base       in  first instruction address, sampled on start
//   inst_mem_rd     out RAM read strobe
//   inst_mem_addr   out RAM read address
//   inst_mem_data   in  RAM read data, valid one cycle after inst_mem_rd
//   clp_instruction out instruction held for CLP_ctr
//   clp_enable      out one-cycle enable per issued instruction
//   clp_state       in  CLP_ctr busy (1 = layer in progress)
//   busy            out high from start until end of program
//   done            out one-cycle end-of-program pulse
//   inst_count      out instructions issued in this run
//   error           out sticky ack/timeout fault, cleared by start
// -----------------------------------------------------------------------------
module clp_inst_dispatch #(
    parameter int INST_WIDTH  = 100,
    parameter int IADDR_W     = 8,
    parameter int MAX_INST    = 64,
    parameter int ACK_WAIT    = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IADDR_W-1:0]    prog_base,
    output logic                  inst_mem_rd,
    output logic [IADDR_W-1:0]    inst_mem_addr,
    input  logic [INST_WIDTH-1:0] inst_mem_data,
    output logic [INST_WIDTH-1:0] clp_instruction,
    output logic                  clp_enable,
    input  logic                  clp_state,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            inst_count,
    output logic                  error
);

    import clp_pkg::*;

    state_t                r_state;
    state_t                w_next;
    logic [IADDR_W-1:0]    r_pc;
    logic [INST_WIDTH-1:0] r_inst;
    logic [7:0]            r_count;
    logic                  r_busy;
    logic                  r_error;
    logic [7:0]            r_ack_cnt;

    logic                  w_stop;
    logic                  w_ack_exp;
    logic                  w_tmo_exp;

    // HALT and the issue cap are both checked before the word is issued
    assign w_stop    = (inst_type(inst_mem_data) == OP_HALT) || (r_count == 8'(MAX_INST));
    assign w_ack_exp = (r_ack_cnt == 8'(ACK_WAIT - 1));

`ifdef DISPATCH_TIMEOUT_EN
    logic [15:0] r_tmo;

    // Busy watchdog: counts cycles spent in RUN, cleared elsewhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= 16'd0;
        end else if (r_state == ST_RUN) begin
            r_tmo <= r_tmo + 16'd1;
        end else begin
            r_tmo <= 16'd0;
        end
    end

    assign w_tmo_exp = (r_tmo == 16'(TIMEOUT_CYC - 1));
`else
    assign w_tmo_exp = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_FETCH; else w_next = ST_IDLE;
            ST_FETCH:   w_next = ST_WAIT_RD;
            ST_WAIT_RD: w_next = ST_LATCH;
            ST_LATCH:   if (w_stop) w_next = ST_DONE; else w_next = ST_ISSUE;
            ST_ISSUE:   w_next = ST_ACK;
            ST_ACK: begin
                // a clp_state that is already high counts as the acknowledge
                if (clp_state)      w_next = ST_RUN;
                else if (w_ack_exp) w_next = ST_DONE;
                else                w_next = ST_ACK;
            end
            ST_RUN: begin
                if (!clp_state)     w_next = ST_FETCH;
                else if (w_tmo_exp) w_next = ST_DONE;
                else                w_next = ST_RUN;
            end
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Datapath: program counter, held instruction, counters, status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= '0;
            r_inst    <= '0;
            r_count   <= 8'd0;
            r_busy    <= 1'b0;
            r_error   <= 1'b0;
            r_ack_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pc    <= prog_base;
                        r_count <= 8'd0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (!w_stop) begin
                        r_inst <= inst_mem_data;
                    end
                end
                ST_ISSUE: begin
                    r_count   <= r_count + 8'd1;
                    r_pc      <= r_pc + {{(IADDR_W-1){1'b0}}, 1'b1};
                    r_ack_cnt <= 8'd0;
                end
                ST_ACK: begin
                    if (!clp_state) begin
                        if (w_ack_exp) begin
                            r_error <= 1'b1;
                        end else begin
                            r_ack_cnt <= r_ack_cnt + 8'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (clp_state && w_tmo_exp) begin
                        r_error <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= r_busy;
                end
            endcase
        end
    end

    assign inst_mem_rd     = (r_state == ST_FETCH);
    assign inst_mem_addr   = r_pc;
    assign clp_instruction = r_inst;
    assign clp_enable      = (r_state == ST_ISSUE);
    assign done            = (r_state == ST_DONE);
    assign busy            = r_busy;
    assign inst_count      = r_count;
    assign error           = r_error;

endmodule

// File: tb/tb_clp_inst_dispatch.sv
// -----------------------------------------------------------------------------
// tb_clp_inst_dispatch
// Scoreboard bench for clp_inst_dispatch. Stimulus pushes the expected issued
// words and the expected end-of-program status into queues; a monitor pops and
// compares them whenever the DUT pulses clp_enable or done. A small RAM model
// and a CLP_ctr model (configurable busy length, optional no-acknowledge) drive
// the DUT inputs.
// -----------------------------------------------------------------------------
module tb_clp_inst_dispatch;

    localparam int IW = 100;
    localparam int AW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [AW-1:0]  prog_base = '0;
    logic           inst_mem_rd;
    logic [AW-1:0]  inst_mem_addr;
    logic [IW-1:0]  inst_mem_data = '0;
    logic [IW-1:0]  clp_instruction;
    logic           clp_enable;
    logic           clp_state = 1'b0;
    logic           busy;
    logic           done;
    logic [7:0]     inst_count;
    logic           error;

    clp_inst_dispatch #(
        .INST_WIDTH (IW),
        .IADDR_W    (AW),
        .MAX_INST   (3),
        .ACK_WAIT   (4),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .prog_base      (prog_base),
        .inst_mem_rd    (inst_mem_rd),
        .inst_mem_addr  (inst_mem_addr),
        .inst_mem_data  (inst_mem_data),
        .clp_instruction(clp_instruction),
        .clp_enable     (clp_enable),
        .clp_state      (clp_state),
        .busy           (busy),
        .done           (done),
        .inst_count     (inst_count),
        .error          (error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [3:0] t, input logic [7:0] tag);
        logic [IW-1:0] w;
        w = {24'hC0FFEE, 64'h0123_4567_89AB_CDEF ^ {8{tag}}, tag, t};
        return w;
    endfunction

    // RAM model with read log
    logic [IW-1:0] mem [0:255];
    int            rd_log [0:1023];
    int            rd_n = 0;

    always @(posedge clk) begin
        if (inst_mem_rd) begin
            inst_mem_data <= mem[inst_mem_addr];
            rd_log[rd_n]  <= int'(inst_mem_addr);
            rd_n          <= rd_n + 1;
        end
    end

    // CLP_ctr model: raises clp_state after an enable for busy_len cycles
    int busy_len = 50;
    bit no_ack   = 1'b0;
    int bcnt     = 0;

    always @(posedge clk) begin
        if (clp_enable && !no_ack) begin
            clp_state <= 1'b1;
            bcnt      <= busy_len - 1;
        end else if (clp_state) begin
            if (bcnt == 0) clp_state <= 1'b0;
            else           bcnt      <= bcnt - 1;
        end
    end

    // Scoreboard queues
    logic [IW-1:0] exp_inst [$];
    logic [8:0]    exp_done [$];
    logic [IW-1:0] cur_inst = '0;
    int            n_en = 0;
    int            n_done = 0;
    int            en_cyc = 0;
    int            done_cyc = 0;

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (clp_enable) begin
                chk("enable_while_clp_busy", 128'(clp_state), 128'(0));
                if (exp_inst.size() == 0) begin
                    chk("unexpected_enable", 128'(1), 128'(0));
                end else begin
                    cur_inst = exp_inst.pop_front();
                    chk("issued_instruction", 128'(clp_instruction), 128'(cur_inst));
                end
                en_cyc = cyc;
                n_en++;
            end else if (busy && clp_state) begin
                chk("instruction_hold", 128'(clp_instruction), 128'(cur_inst));
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 128'(1), 128'(0));
                end else begin
                    logic [8:0] e;
                    e = exp_done.pop_front();
                    chk("done_inst_count", 128'(inst_count), 128'(e[8:1]));
                    chk("done_error", 128'(error), 128'(e[0]));
                end
                done_cyc = cyc;
                n_done++;
            end
        end
    end

    task automatic pulse_start(input logic [AW-1:0] base, output int s);
        @(posedge clk); #1;
        prog_base = base;
        start     = 1'b1;
        s         = cyc;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        bit seen;
        n0   = n_done;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_done != n0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 128'(0), 128'(1));
        @(negedge clk);
        chk("busy_after_done", 128'(busy), 128'(0));
        chk("done_single_pulse", 128'(done), 128'(0));
        chk("scoreboard_enables_left", 128'(exp_inst.size()), 128'(0));
        chk("scoreboard_done_left", 128'(exp_done.size()), 128'(0));
    endtask

    task automatic chk_last_read(input string nm, input int n0, input int exp_max);
        int mx;
        mx = -1;
        for (int i = n0; i < rd_n; i++) if (rd_log[i] > mx) mx = rd_log[i];
        chk(nm, 128'(mx), 128'(exp_max));
    endtask

    task automatic wait_clp(input logic lvl, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (clp_state == lvl) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("clp_state_wait_timeout", 128'(0), 128'(1));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, 128'(busy), 128'(0));
        chk({nm, "_done"}, 128'(done), 128'(0));
        chk({nm, "_enable"}, 128'(clp_enable), 128'(0));
        chk({nm, "_rd"}, 128'(inst_mem_rd), 128'(0));
        chk({nm, "_addr"}, 128'(inst_mem_addr), 128'(0));
        chk({nm, "_count"}, 128'(inst_count), 128'(0));
        chk({nm, "_error"}, 128'(error), 128'(0));
        chk({nm, "_instr"}, 128'(clp_instruction), 128'(0));
    endtask

    initial begin
        int s;
        int n0;
        int n_en0;
        for (int i = 0; i < 256; i++) mem[i] = mk(4'h2, 8'(i));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // 1) two conv words then HALT; also checks start-to-enable latency
        mem[8'h10] = mk(4'h1, 8'h01);
        mem[8'h11] = mk(4'h1, 8'h02);
        mem[8'h12] = mk(4'hF, 8'h03);
        busy_len = 50;
        exp_inst.push_back(mk(4'h1, 8'h01));
        exp_inst.push_back(mk(4'h1, 8'h02));
        exp_done.push_back({8'd2, 1'b0});
        n0 = rd_n;
        n_en0 = n_en;
        pulse_start(8'h10, s);
        for (int i = 0; i < 20 && n_en == n_en0; i++) @(negedge clk);
        chk("start_to_enable_latency", 128'(en_cyc - s), 128'(4));
        wait_done(400);
        chk("t1_enable_count", 128'(n_en - n_en0), 128'(2));
        chk_last_read("t1_last_read_addr", n0, 8'h12);

        // 3) CLP never acknowledges
        mem[8'h20] = mk(4'h1, 8'h09);
        mem[8'h21] = mk(4'h1, 8'h0A);
        no_ack = 1'b1;
        exp_inst.push_back(mk(4'h1, 8'h09));
        exp_done.push_back({8'd1, 1'b1});
        n0 = rd_n;
        pulse_start(8'h20, s);
        wait_done(100);
        chk("ack_timeout_delay", 128'(done_cyc - en_cyc), 128'(5));
        chk_last_read("t3_last_read_addr", n0, 8'h20);
        no_ack = 1'b0;

        // 4) issue cap of 3 with five non-HALT words
        for (int i = 0; i < 5; i++) mem[8'h30 + i] = mk(4'h3, 8'(8'h40 + i));
        busy_len = 3;
        for (int i = 0; i < 3; i++) exp_inst.push_back(mk(4'h3, 8'(8'h40 + i)));
        exp_done.push_back({8'd3, 1'b0});
        n0 = rd_n;
        pulse_start(8'h30, s);
        wait_done(200);
        chk_last_read("t4_last_read_addr", n0, 8'h33);

        // 5) start during RUN is ignored; async reset mid-RUN; clean rerun
        mem[8'h40] = mk(4'h1, 8'h20);
        mem[8'h41] = mk(4'h1, 8'h21);
        mem[8'h42] = mk(4'hF, 8'h22);
        busy_len = 30;
        exp_inst.push_back(mk(4'h1, 8'h20));
        exp_inst.push_back(mk(4'h1, 8'h21));
        exp_done.push_back({8'd2, 1'b0});
        pulse_start(8'h40, s);
        wait_clp(1'b1, 20);
        repeat (2) @(negedge clk);
        pulse_start(8'h77, s);
        @(negedge clk);
        chk("ignored_start_busy", 128'(busy), 128'(1));
        chk("ignored_start_rd", 128'(inst_mem_rd), 128'(0));
        chk("ignored_start_count", 128'(inst_count), 128'(1));
        chk("ignored_start_addr", 128'(inst_mem_addr), 128'(8'h41));
        #2 rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        exp_inst.delete();
        exp_done.delete();
        wait_clp(1'b0, 60);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_inst.push_back(mk(4'h1, 8'h20));
        exp_inst.push_back(mk(4'h1, 8'h21));
        exp_done.push_back({8'd2, 1'b0});
        n0 = rd_n;
        pulse_start(8'h40, s);
        wait_done(300);
        chk_last_read("t5_last_read_addr", n0, 8'h42);

        // 6) long busy period against the optional watchdog
        mem[8'h50] = mk(4'h1, 8'h30);
        mem[8'h51] = mk(4'hF, 8'h31);
        busy_len = 200;
        exp_inst.push_back(mk(4'h1, 8'h30));
        n0 = rd_n;
`ifdef DISPATCH_TIMEOUT_EN
        exp_done.push_back({8'd1, 1'b1});
        pulse_start(8'h50, s);
        wait_done(400);
        chk("watchdog_delay", 128'(done_cyc - en_cyc), 128'(102));
        chk_last_read("t6_last_read_addr", n0, 8'h50);
        wait_clp(1'b0, 200);
`else
        exp_done.push_back({8'd1, 1'b0});
        pulse_start(8'h50, s);
        wait_done(400);
        chk_last_read("t6_last_read_addr", n0, 8'h51);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
